ram_uart_dump: RTL and testbench
================================

RAM_UART_DUMP -- requirements
Module: ram_uart_dump

Interface
REQ-001 Parameter ADDR_W, 15, RAM address width.
REQ-002 Parameter SYNC_BYTE, 8'hAA, frame header byte.
REQ-003 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle dump request.
REQ-006 start_addr  input  ADDR_W  first RAM address to read, sampled on accepted start.
REQ-007 length  input  16  byte count to send, sampled on accepted start; legal range 0..2^ADDR_W.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  single-cycle pulse when the last frame byte completes.
REQ-010 ram_addr  output  ADDR_W  RAM read address.
REQ-011 ram_rd_data  input  8  RAM read data, valid 2 cycles after ram_addr changes (registered-address, registered-output RAM).
REQ-012 uart_wr_data  output  8  byte to transmit, held stable while waiting for completion.
REQ-013 uart_wr_en  output  1  single-cycle send request to the UART transmitter.
REQ-014 uart_wr_complete  input  1  single-cycle pulse from the transmitter when the byte has been sent.

Function
REQ-015 The block SHALL emit a frame: SYNC_BYTE, length[15:8], length[7:0], length data bytes from RAM, then checksum.
REQ-016 Checksum SHALL be the 8-bit modulo-256 sum of length[15:8], length[7:0] and all data bytes; SYNC_BYTE is excluded.
REQ-017 States SHALL be IDLE, HDR, LEN_H, LEN_L, RD_REQ, RD_WAIT, DATA, CSUM, each send state splitting into issue and wait-for-complete.
REQ-018 IDLE->HDR on start; HDR->LEN_H->LEN_L on each uart_wr_complete; LEN_L->RD_REQ if length!=0, else ->CSUM.
REQ-019 RD_REQ drives ram_addr, RD_WAIT counts 2 cycles, DATA sends the captured byte; after its complete, -> RD_REQ if bytes remain, else ->CSUM.
REQ-020 CSUM->IDLE on uart_wr_complete, asserting done that same cycle and deasserting busy the next.
REQ-021 Each byte SHALL produce exactly one uart_wr_en pulse; the next pulse SHALL NOT be issued before the previous byte's uart_wr_complete.
REQ-022 uart_wr_en SHALL be asserted no earlier than the cycle after uart_wr_complete of the prior byte.
REQ-023 uart_wr_complete arriving while not in a wait sub-state SHALL be ignored.
REQ-024 start while busy SHALL be ignored; start_addr and length SHALL NOT be resampled.
REQ-025 start and the final uart_wr_complete in the same cycle: start SHALL be ignored.
REQ-026 RAM address SHALL increment by one per data byte and wrap from 2^ADDR_W-1 to 0.
REQ-027 The remaining-byte counter SHALL be 17 bits wide so that length=2^ADDR_W (32768) completes correctly.
REQ-028 ram_addr SHALL hold its last value when idle.

Reset
REQ-029 sys_rst SHALL force IDLE, with busy=0, done=0, uart_wr_en=0, uart_wr_data=0, ram_addr=0, checksum=0, counters=0.
REQ-030 sys_rst mid-frame SHALL abort immediately with no further uart_wr_en; a complete arriving later SHALL be ignored.

Structure
REQ-031 State encoding, SYNC_BYTE and the RAM read latency (2) SHALL live in shared package thz_pkg.
REQ-032 The single FSM with datapath counters SHALL be one module; no sub-module.
REQ-033 The block SHALL share the RAM read port with sys_control through an external mux selected by busy.

Verification
REQ-034 start_addr=0x0010, length=3, RAM[0x10..0x12]=0x01,0x02,0x03, complete 20 cycles after each en -> bytes AA,00,03,01,02,03,09; one done pulse.
REQ-035 length=0 -> bytes AA,00,00,00; no RAM read issued; done.
REQ-036 start_addr=0x7FFF, length=2, RAM[0x7FFF]=0xF0, RAM[0]=0x20 -> ram_addr 0x7FFF then 0x0000; bytes AA,00,02,F0,20,12.
REQ-037 Second start during frame and spurious complete in IDLE -> frame unchanged, no extra uart_wr_en.
REQ-038 sys_rst asserted after the 2nd data byte's en -> next cycle busy=0 and uart_wr_en=0; a new start then yields a correct full frame.
REQ-039 length=32768, start_addr=0 -> 32772 bytes total, address wraps to 0 after the last byte, done once.

Source files
------------

// File: rtl/thz_pkg.sv
// Shared definitions for the RAM-to-UART dump block: FSM state encoding,
// default frame header byte and RAM read latency.
package thz_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
  localparam int         RD_LAT            = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_ISSUE,
    ST_HDR_WAIT,
    ST_LEN_H_ISSUE,
    ST_LEN_H_WAIT,
    ST_LEN_L_ISSUE,
    ST_LEN_L_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DATA_ISSUE,
    ST_DATA_WAIT,
    ST_CSUM_ISSUE,
    ST_CSUM_WAIT
  } state_e;

  // Issue sub-states are the only cycles in which a byte is handed to the UART.
  function automatic logic is_issue(state_e s);
    return (s == ST_HDR_ISSUE) || (s == ST_LEN_H_ISSUE) || (s == ST_LEN_L_ISSUE) ||
           (s == ST_DATA_ISSUE) || (s == ST_CSUM_ISSUE);
  endfunction

endpackage

// File: rtl/ram_uart_dump.sv
// Reads a block of RAM and sends it over a UART as a framed, checksummed packet:
// SYNC, len_hi, len_lo, data..., checksum (sum of length bytes and data).
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_IDLE        | waiting for start, ram_addr held
// ST_HDR_*       | send SYNC byte (issue / wait for complete)
// ST_LEN_H_*     | send length[15:8]
// ST_LEN_L_*     | send length[7:0]
// ST_RD_REQ      | ram_addr is on the bus, arm read-latency countdown
// ST_RD_WAIT     | count down RAM latency, capture read data at terminal count
// ST_DATA_*      | send captured data byte, then advance address
// ST_CSUM_*      | send checksum, done on its complete
module ram_uart_dump #(
  parameter int         ADDR_W    = 15,
  parameter logic [7:0] SYNC_BYTE = thz_pkg::SYNC_BYTE_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [7:0]        uart_wr_data,
  output logic              uart_wr_en,
  input  logic              uart_wr_complete
);

  import thz_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       remain_q, remain_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        wait_q, wait_d;
  logic [7:0]        data_q, data_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      remain_q <= '0;
      csum_q   <= '0;
      wait_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      csum_q   <= csum_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
    end
  end

  // Next-state and datapath updates; the outgoing byte is loaded on entry to each issue state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    remain_d = remain_q;
    csum_d   = csum_q;
    wait_d   = wait_q;
    data_d   = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_HDR_ISSUE;
          len_d    = length;
          remain_d = {1'b0, length};
          csum_d   = '0;
          data_d   = SYNC_BYTE;
          // Only move the shared read port when a read will actually follow.
          if (length != 16'd0) addr_d = start_addr;
        end
      end
      ST_HDR_ISSUE: state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        if (uart_wr_complete) begin
          state_d = ST_LEN_H_ISSUE;
          data_d  = len_q[15:8];
          csum_d  = csum_q + len_q[15:8];
        end
      end
      ST_LEN_H_ISSUE: state_d = ST_LEN_H_WAIT;
      ST_LEN_H_WAIT: begin
        if (uart_wr_complete) begin
          state_d = ST_LEN_L_ISSUE;
          data_d  = len_q[7:0];
          csum_d  = csum_q + len_q[7:0];
        end
      end
      ST_LEN_L_ISSUE: state_d = ST_LEN_L_WAIT;
      ST_LEN_L_WAIT: begin
        if (uart_wr_complete) begin
          if (remain_q != 17'd0) begin
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_CSUM_ISSUE;
            data_d  = csum_q;
          end
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
        wait_d  = 2'(RD_LAT - 1);
      end
      ST_RD_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d  = ST_DATA_ISSUE;
          data_d   = ram_rd_data;
          csum_d   = csum_q + ram_rd_data;
          remain_d = remain_q - 17'd1;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_DATA_ISSUE: state_d = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (uart_wr_complete) begin
          addr_d = addr_q + ADDR_W'(1);
          if (remain_q != 17'd0) begin
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_CSUM_ISSUE;
            data_d  = csum_q;
          end
        end
      end
      ST_CSUM_ISSUE: state_d = ST_CSUM_WAIT;
      ST_CSUM_WAIT: begin
        if (uart_wr_complete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_CSUM_WAIT) && uart_wr_complete;
    uart_wr_en   = is_issue(state_q);
    uart_wr_data = data_q;
    ram_addr     = addr_q;
  end

endmodule

// File: tb/tb_ram_uart_dump.sv
// Scoreboard bench for ram_uart_dump: frames are predicted from RAM contents
// when a dump is started, and a monitor checks every byte the DUT hands to the UART.
module tb_ram_uart_dump;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   length = '0;
  logic          busy, done, uart_wr_en;
  logic          uart_wr_complete = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rd_data, uart_wr_data;

  always #5 clk = ~clk;

  ram_uart_dump #(.ADDR_W(AW), .SYNC_BYTE(8'hAA)) dut (
    .sys_clk          (clk),
    .sys_rst          (rst),
    .start            (start),
    .start_addr       (start_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .ram_addr         (ram_addr),
    .ram_rd_data      (ram_rd_data),
    .uart_wr_data     (uart_wr_data),
    .uart_wr_en       (uart_wr_en),
    .uart_wr_complete (uart_wr_complete)
  );

  // RAM model: registered address, registered output.
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] addr_r1;
  always @(posedge clk) begin
    addr_r1     <= ram_addr;
    ram_rd_data <= mem[addr_r1];
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] expq[$];
  int         sent_cnt = 0;
  int         done_cnt = 0;
  bit         outstanding = 0;
  int         cpl_dly = 1;
  bit         spur_req = 0;
  logic [AW-1:0] model_addr = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: header, length bytes, data with address wrap, mod-256 checksum.
  task automatic push_frame(logic [AW-1:0] a, logic [15:0] n);
    int sum;
    logic [7:0] b;
    sum = int'(n[15:8]) + int'(n[7:0]);
    expq.push_back(8'hAA);
    expq.push_back(n[15:8]);
    expq.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      b = mem[(int'(a) + i) % DEPTH];
      expq.push_back(b);
      sum += int'(b);
    end
    expq.push_back(8'(sum % 256));
  endtask

  // Monitor: every send request is checked against the scoreboard and the handshake rule.
  always @(negedge clk) begin : mon
    logic [7:0] exp_b;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (uart_wr_en) begin
        sent_cnt++;
        check("en_before_complete", 32'(outstanding), 32'd0);
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %02h expected no byte", uart_wr_data);
        end else begin
          exp_b = expq.pop_front();
          check("frame_byte", 32'(uart_wr_data), 32'(exp_b));
        end
        outstanding = 1;
      end
      if (uart_wr_complete) outstanding = 0;
      if (done) done_cnt++;
    end
  end

  // UART transmitter model: completes each byte cpl_dly cycles after its request.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_wr_en && !rst) begin
        repeat (cpl_dly) @(posedge clk);
        #1 uart_wr_complete = 1'b1;
        @(posedge clk);
        #1 uart_wr_complete = 1'b0;
      end else if (spur_req) begin
        spur_req = 0;
        @(posedge clk);
        #1 uart_wr_complete = 1'b1;
        @(posedge clk);
        #1 uart_wr_complete = 1'b0;
      end
    end
  end

  task automatic run_frame(logic [AW-1:0] a, logic [15:0] n, int dly, bit dup_start, bit collide);
    int base_done;
    int budget;
    bit got;
    cpl_dly = dly;
    push_frame(a, n);
    base_done = done_cnt;
    @(posedge clk);
    #1 start = 1'b1; start_addr = a; length = n;
    @(posedge clk);
    #1 start = 1'b0; start_addr = AW'($urandom); length = 16'($urandom_range(1, 40));
    check("busy_after_start", 32'(busy), 32'd1);
    if (dup_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    budget = (int'(n) + 4) * (dly + 8) + 50;
    got = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #2;
      if (done) begin
        got = 1;
        if (collide) start = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt), 32'(base_done + 1));
    check("frame_consumed", 32'(expq.size()), 32'd0);
    if (n != 16'd0) model_addr = AW'((int'(a) + int'(n)) % DEPTH);
    check("ram_addr_after", 32'(ram_addr), 32'(model_addr));
    repeat (3) @(posedge clk);
    check("idle_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_frame();
    int base_sent;
    int base_done;
    bit got;
    cpl_dly = 3;
    push_frame(AW'(100), 16'd5);
    base_sent = sent_cnt;
    base_done = done_cnt;
    @(posedge clk);
    #1 start = 1'b1; start_addr = AW'(100); length = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (sent_cnt >= base_sent + 5) begin
        got = 1;
        break;
      end
    end
    check("reached_2nd_data", 32'(got), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(uart_wr_en), 32'd0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_addr = '0;
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("no_en_after_rst", 32'(sent_cnt), 32'(base_sent + 5));
    check("no_done_after_rst", 32'(done_cnt), 32'(base_done));
    check("idle_after_late_cpl", 32'(busy), 32'd0);
  endtask

  initial begin
    int base_sent;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_en", 32'(uart_wr_en), 32'd0);
    check("reset_data", 32'(uart_wr_data), 32'd0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic three-byte dump, slow transmitter.
    mem[16] = 8'h01; mem[17] = 8'h02; mem[18] = 8'h03;
    run_frame(AW'(16), 16'd3, 20, 0, 0);

    // Zero length: header and checksum only, RAM port untouched.
    run_frame(AW'(16'h155), 16'd0, 2, 0, 0);

    // Address wrap at the top of the RAM.
    mem[DEPTH-1] = 8'hF0; mem[0] = 8'h20;
    run_frame(AW'(DEPTH - 1), 16'd2, 2, 0, 0);

    // Spurious complete while idle, then a frame with a second start mid-frame.
    base_sent = sent_cnt;
    spur_req = 1;
    repeat (6) @(posedge clk);
    #1;
    check("spurious_no_en", 32'(sent_cnt), 32'(base_sent));
    check("spurious_idle", 32'(busy), 32'd0);
    run_frame(AW'(200), 16'd4, 3, 1, 0);

    // Start coinciding with the final complete.
    run_frame(AW'(300), 16'd2, 1, 0, 1);

    reset_mid_frame();
    run_frame(AW'(100), 16'd5, 2, 0, 0);

    for (int k = 0; k < 8; k++) begin
      run_frame(AW'($urandom), 16'($urandom_range(0, 12)), $urandom_range(1, 4), 0, 0);
    end

    // Full address space in one frame.
    run_frame(AW'(0), 16'(DEPTH), 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
